// File: rtl/ldq_pkg.sv
// ldq_pkg - shared types and default widths for the load queue.
// Entry struct holds allocation/status flags plus address, dest reg and ROB tag.
package ldq_pkg;
  localparam int LDQ_WIDTH_ADDR = 32;
  localparam int LDQ_WIDTH_REG  = 5;
  localparam int LDQ_WIDTH_TAG  = 5;
  localparam int LDQ_WIDTH      = 3;
  localparam int LDQ_SIZE       = 2 ** LDQ_WIDTH;

  typedef struct packed {
    logic                      a;
    logic                      v;
    logic                      m;
    logic                      i;
    logic [LDQ_WIDTH_ADDR-1:0] addr;
    logic [LDQ_WIDTH_REG-1:0]  rd;
    logic [LDQ_WIDTH_TAG-1:0]  tag;
  } ldq_ent_t;
endpackage

// File: rtl/ldq_if.sv
// ldq_if - load queue port bundle; master drives requests, slave is the queue.
// Flush signals exist only when LDQ_FLUSH_EN is defined.
interface ldq_if
  import ldq_pkg::*;
#(
  parameter int WIDTH_ADDR = LDQ_WIDTH_ADDR,
  parameter int WIDTH_REG  = LDQ_WIDTH_REG,
  parameter int WIDTH_TAG  = LDQ_WIDTH_TAG,
  parameter int WIDTH      = LDQ_WIDTH
) ();
  logic                  i_enq_val;
  logic [WIDTH_REG-1:0]  i_enq_rd;
  logic [WIDTH_TAG-1:0]  i_enq_tag;
  logic                  o_enq_rdy;
  logic [WIDTH-1:0]      o_enq_idx;
  logic                  i_agu_val;
  logic [WIDTH-1:0]      i_agu_idx;
  logic [WIDTH_ADDR-1:0] i_agu_addr;
  logic                  i_miss_val;
  logic [WIDTH-1:0]      i_miss_idx;
  logic                  i_replay_val;
  logic [WIDTH-1:0]      i_replay_idx;
  logic                  o_wkup_val;
  logic [WIDTH-1:0]      o_wkup_idx;
  logic [WIDTH_ADDR-1:0] o_wkup_addr;
  logic                  i_wkup_ack;
  logic                  i_deq;
  logic [WIDTH_REG-1:0]  o_head_rd;
  logic [WIDTH_TAG-1:0]  o_head_tag;
  logic                  o_head_done;
  logic                  o_empty;
  logic                  o_full;
  logic [WIDTH:0]        o_count;
`ifdef LDQ_FLUSH_EN
  logic                  i_flush_val;
  logic [WIDTH-1:0]      i_flush_idx;
`endif

  modport master (
`ifdef LDQ_FLUSH_EN
    output i_flush_val, i_flush_idx,
`endif
    output i_enq_val, i_enq_rd, i_enq_tag,
    output i_agu_val, i_agu_idx, i_agu_addr,
    output i_miss_val, i_miss_idx,
    output i_replay_val, i_replay_idx,
    output i_wkup_ack, i_deq,
    input  o_enq_rdy, o_enq_idx,
    input  o_wkup_val, o_wkup_idx, o_wkup_addr,
    input  o_head_rd, o_head_tag, o_head_done,
    input  o_empty, o_full, o_count
  );

  modport slave (
`ifdef LDQ_FLUSH_EN
    input  i_flush_val, i_flush_idx,
`endif
    input  i_enq_val, i_enq_rd, i_enq_tag,
    input  i_agu_val, i_agu_idx, i_agu_addr,
    input  i_miss_val, i_miss_idx,
    input  i_replay_val, i_replay_idx,
    input  i_wkup_ack, i_deq,
    output o_enq_rdy, o_enq_idx,
    output o_wkup_val, o_wkup_idx, o_wkup_addr,
    output o_head_rd, o_head_tag, o_head_done,
    output o_empty, o_full, o_count
  );
endinterface

// File: rtl/ldq_age_pick.sv
// ldq_age_pick - oldest-first picker over a circular queue.
// Scans from head forward; index arithmetic wraps because SIZE is a power of 2.
module ldq_age_pick
  import ldq_pkg::*;
#(
  parameter int WIDTH = LDQ_WIDTH,
  parameter int SIZE  = 2 ** WIDTH
) (
  input  logic [SIZE-1:0]  elig,
  input  logic [WIDTH-1:0] head,
  output logic             val,
  output logic [WIDTH-1:0] idx
);
  logic [WIDTH-1:0] k;

  always_comb begin
    val = 1'b0;
    idx = '0;
    k   = '0;
    for (int i = 0; i < SIZE; i++) begin
      k = head + i[WIDTH-1:0];
      if (!val && elig[k]) begin
        val = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/ldq.sv
// ldq - load queue: in-order allocate/retire, wakeup of the oldest issuable load.
// Define LDQ_FLUSH_EN to add the flush-younger port (i_flush_val/i_flush_idx).
module ldq
  import ldq_pkg::*;
#(
  parameter int WIDTH_ADDR = LDQ_WIDTH_ADDR,
  parameter int WIDTH_REG  = LDQ_WIDTH_REG,
  parameter int WIDTH_TAG  = LDQ_WIDTH_TAG,
  parameter int WIDTH      = LDQ_WIDTH,
  parameter int SIZE       = 2 ** WIDTH
) (
  input logic  i_clk,
  input logic  i_rst_n,
  ldq_if.slave bus
);
  ldq_ent_t q [SIZE];

  logic [WIDTH-1:0]      head, tail, head_n, tail_n;
  logic [WIDTH:0]        count, count_n;
  logic                  full, empty;
  logic                  enq_go, deq_go, ack_go;
  logic [SIZE-1:0]       elig;
  logic                  wk_val;
  logic [WIDTH-1:0]      wk_idx;
  logic [WIDTH_ADDR-1:0] wk_addr;
  logic [WIDTH_REG-1:0]  hd_rd;
  logic [WIDTH_TAG-1:0]  hd_tag;
`ifdef LDQ_FLUSH_EN
  logic                  fl_ok;
  logic [WIDTH-1:0]      fl_off, age;
  logic [SIZE-1:0]       kill;
`endif

  assign full  = (count == (WIDTH+1)'(SIZE));
  assign empty = (count == '0);

  always_comb begin
    for (int k = 0; k < SIZE; k++)
      elig[k] = q[k].a & q[k].v & ~q[k].m & ~q[k].i;
  end

  ldq_age_pick #(.WIDTH(WIDTH), .SIZE(SIZE)) u_pick (
    .elig (elig),
    .head (head),
    .val  (wk_val),
    .idx  (wk_idx)
  );

  assign ack_go = wk_val & bus.i_wkup_ack;

  always_comb begin
    enq_go = bus.i_enq_val & ~full;
    deq_go = bus.i_deq & ~empty;
`ifdef LDQ_FLUSH_EN
    fl_off = bus.i_flush_idx - head;
    fl_ok  = bus.i_flush_val && ({1'b0, fl_off} < count);
    kill   = '0;
    age    = '0;
    for (int k = 0; k < SIZE; k++) begin
      age     = WIDTH'(k) - head;
      kill[k] = fl_ok && (age >= fl_off) && ({1'b0, age} < count);
    end
    // Flushing the head itself empties the queue; nothing is left to retire.
    if (fl_ok) begin
      enq_go = 1'b0;
      deq_go = deq_go && (fl_off != '0);
    end
`endif
    head_n  = deq_go ? head + 1'b1 : head;
    tail_n  = enq_go ? tail + 1'b1 : tail;
    count_n = count + {{WIDTH{1'b0}}, enq_go} - {{WIDTH{1'b0}}, deq_go};
`ifdef LDQ_FLUSH_EN
    if (fl_ok) begin
      tail_n  = bus.i_flush_idx;
      count_n = {1'b0, fl_off} - {{WIDTH{1'b0}}, deq_go};
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < SIZE; k++)
        q[k] <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      for (int k = 0; k < SIZE; k++) begin
        if (deq_go && head == WIDTH'(k))
          q[k].a <= 1'b0;
        // Status updates only touch live entries; replay is last so it wins.
        if (q[k].a) begin
          if (bus.i_agu_val && bus.i_agu_idx == WIDTH'(k)) begin
            q[k].v    <= 1'b1;
            q[k].addr <= bus.i_agu_addr;
          end
          if (ack_go && wk_idx == WIDTH'(k))
            q[k].i <= 1'b1;
          if (bus.i_miss_val && bus.i_miss_idx == WIDTH'(k)) begin
            q[k].m <= 1'b1;
            q[k].i <= 1'b0;
          end
          if (bus.i_replay_val && bus.i_replay_idx == WIDTH'(k)) begin
            q[k].m <= 1'b0;
            q[k].i <= 1'b0;
          end
        end
        if (enq_go && tail == WIDTH'(k)) begin
          q[k].a   <= 1'b1;
          q[k].v   <= 1'b0;
          q[k].m   <= 1'b0;
          q[k].i   <= 1'b0;
          q[k].rd  <= bus.i_enq_rd;
          q[k].tag <= bus.i_enq_tag;
        end
`ifdef LDQ_FLUSH_EN
        if (kill[k])
          q[k].a <= 1'b0;
`endif
      end
    end
  end

  assign wk_addr = wk_val ? q[wk_idx].addr : '0;
  assign hd_rd   = q[head].rd;
  assign hd_tag  = q[head].tag;

  assign bus.o_enq_rdy   = ~full;
  assign bus.o_enq_idx   = tail;
  assign bus.o_wkup_val  = wk_val;
  assign bus.o_wkup_idx  = wk_idx;
  assign bus.o_wkup_addr = wk_addr;
  assign bus.o_head_rd   = hd_rd;
  assign bus.o_head_tag  = hd_tag;
  assign bus.o_head_done = q[head].a & q[head].v
                         & q[head].i & ~q[head].m;
  assign bus.o_empty     = empty;
  assign bus.o_full      = full;
  assign bus.o_count     = count;
endmodule

// File: tb/tb_ldq.sv
// tb_ldq - directed scoreboard bench for the load queue.
// Define LDQ_FLUSH_EN to also exercise the flush port.
module tb_ldq;
  import ldq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldq_if bus ();

  ldq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        rdy;
    logic [2:0]  eidx;
    logic        wv;
    logic [2:0]  wi;
    logic [31:0] wa;
    logic        hd;
    logic [4:0]  htag;
  } snap_t;

  typedef struct {
    string nm;
    snap_t v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] A1 = 32'h1111_0001;
  localparam logic [31:0] A7 = 32'h7777_0007;
  localparam logic [31:0] A6 = 32'h6666_0006;
  localparam logic [31:0] A2 = 32'h2222_0002;
  localparam logic [31:0] A0 = 32'hA0A0_0000;

  task automatic want(string nm, int cnt, int eidx, bit wv, int wi,
                      logic [31:0] wa, bit hd, int htag);
    exp_t e;
    e.nm     = nm;
    e.v.cnt  = 4'(cnt);
    e.v.full = (cnt == 8);
    e.v.empty = (cnt == 0);
    e.v.rdy  = (cnt != 8);
    e.v.eidx = 3'(eidx);
    e.v.wv   = wv;
    e.v.wi   = 3'(wi);
    e.v.wa   = wa;
    e.v.hd   = hd;
    e.v.htag = 5'(htag);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    snap_t a;
    if (sb.size() != 0) begin
      e      = sb.pop_front();
      a.cnt  = bus.o_count;
      a.full = bus.o_full;
      a.empty = bus.o_empty;
      a.rdy  = bus.o_enq_rdy;
      a.eidx = bus.o_enq_idx;
      a.wv   = bus.o_wkup_val;
      a.wi   = bus.o_wkup_idx;
      a.wa   = bus.o_wkup_addr;
      a.hd   = bus.o_head_done;
      a.htag = bus.o_head_tag;
      total++;
      if (a !== e.v) begin
        bad++;
        $display("FAIL %s got cnt=%0d fl=%b em=%b rdy=%b eidx=%0d wv=%b wi=%0d wa=%h hd=%b tag=%0d want cnt=%0d fl=%b em=%b rdy=%b eidx=%0d wv=%b wi=%0d wa=%h hd=%b tag=%0d",
                 e.nm, a.cnt, a.full, a.empty, a.rdy, a.eidx, a.wv, a.wi,
                 a.wa, a.hd, a.htag, e.v.cnt, e.v.full, e.v.empty, e.v.rdy,
                 e.v.eidx, e.v.wv, e.v.wi, e.v.wa, e.v.hd, e.v.htag);
      end
    end
  end

  task automatic idle();
    bus.i_enq_val    = 1'b0;
    bus.i_enq_rd     = '0;
    bus.i_enq_tag    = '0;
    bus.i_agu_val    = 1'b0;
    bus.i_agu_idx    = '0;
    bus.i_agu_addr   = '0;
    bus.i_miss_val   = 1'b0;
    bus.i_miss_idx   = '0;
    bus.i_replay_val = 1'b0;
    bus.i_replay_idx = '0;
    bus.i_wkup_ack   = 1'b0;
    bus.i_deq        = 1'b0;
`ifdef LDQ_FLUSH_EN
    bus.i_flush_val  = 1'b0;
    bus.i_flush_idx  = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic enq(int rd, int tag);
    bus.i_enq_val = 1'b1;
    bus.i_enq_rd  = 5'(rd);
    bus.i_enq_tag = 5'(tag);
  endtask

  task automatic agu(int idx, logic [31:0] addr);
    bus.i_agu_val  = 1'b1;
    bus.i_agu_idx  = 3'(idx);
    bus.i_agu_addr = addr;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    tick();
    want("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // fill to full; the ninth enqueue must be dropped
    for (int n = 0; n < 9; n++) begin
      enq(n + 1, n + 16);
      want("fill", (n < 8) ? n : 8, n % 8, 0, 0, 0, 0, (n == 0) ? 0 : 16);
      tick();
    end
    want("full_hold", 8, 0, 0, 0, 0, 0, 16);
    tick();
    bus.i_deq = 1'b1;
    tick();
    want("deq_post", 7, 0, 0, 0, 0, 0, 17);
    tick();

    // move head to 6, allocate 0 and 1 behind it
    for (int n = 0; n < 5; n++) begin
      bus.i_deq = 1'b1;
      tick();
    end
    want("head6", 2, 0, 0, 0, 0, 0, 22);
    tick();
    enq(10, 25);
    tick();
    enq(11, 26);
    tick();
    want("four", 4, 2, 0, 0, 0, 0, 22);
    tick();

    agu(1, A1);
    tick();
    agu(7, A7);
    want("agu1", 4, 2, 1, 1, A1, 0, 22);
    tick();
    bus.i_wkup_ack = 1'b1;
    want("wrap7", 4, 2, 1, 7, A7, 0, 22);
    tick();
    bus.i_miss_val = 1'b1;
    bus.i_miss_idx = 3'd1;
    want("after_ack", 4, 2, 1, 1, A1, 0, 22);
    tick();
    bus.i_replay_val = 1'b1;
    bus.i_replay_idx = 3'd1;
    want("missed", 4, 2, 0, 0, 0, 0, 22);
    tick();
    bus.i_miss_val   = 1'b1;
    bus.i_miss_idx   = 3'd1;
    bus.i_replay_val = 1'b1;
    bus.i_replay_idx = 3'd1;
    want("replayed", 4, 2, 1, 1, A1, 0, 22);
    tick();
    want("rep_wins", 4, 2, 1, 1, A1, 0, 22);
    tick();

    agu(6, A6);
    tick();
    bus.i_wkup_ack = 1'b1;
    want("old6", 4, 2, 1, 6, A6, 0, 22);
    tick();
    want("hdone", 4, 2, 1, 1, A1, 1, 22);
    tick();

    // simultaneous enqueue and dequeue at count 4
    enq(12, 27);
    bus.i_deq = 1'b1;
    want("swap_pre", 4, 2, 1, 1, A1, 1, 22);
    tick();
    want("swap", 4, 3, 1, 1, A1, 1, 23);
    tick();

    for (int n = 0; n < 4; n++) begin
      bus.i_deq = 1'b1;
      tick();
    end
    bus.i_deq = 1'b1;
    want("empty_deq", 0, 3, 0, 0, 0, 0, 19);
    tick();
    want("empty_hold", 0, 3, 0, 0, 0, 0, 19);
    tick();

`ifdef LDQ_FLUSH_EN
    rst_pulse();
    for (int k = 0; k < 6; k++) begin
      enq(k, k + 1);
      tick();
    end
    enq(9, 9);
    bus.i_flush_val = 1'b1;
    bus.i_flush_idx = 3'd3;
    want("six", 6, 6, 0, 0, 0, 0, 1);
    tick();
    want("flushed", 3, 3, 0, 0, 0, 0, 1);
    tick();
    agu(4, 32'h0000_0044);
    tick();
    bus.i_flush_val = 1'b1;
    bus.i_flush_idx = 3'd5;
    want("dead4", 3, 3, 0, 0, 0, 0, 1);
    tick();
    want("flush_oor", 3, 3, 0, 0, 0, 0, 1);
    tick();
    agu(2, A2);
    tick();
    bus.i_flush_val = 1'b1;
    bus.i_flush_idx = 3'd2;
    bus.i_deq       = 1'b1;
    want("live2", 3, 3, 1, 2, A2, 0, 1);
    tick();
    want("flush_deq", 1, 2, 0, 0, 0, 0, 2);
    tick();
`endif

    // reset while full with an ack pending
    rst_pulse();
    for (int k = 0; k < 8; k++) begin
      enq(k, k + 1);
      tick();
    end
    agu(0, A0);
    tick();
    want("full_elig", 8, 0, 1, 0, A0, 0, 1);
    tick();
    bus.i_wkup_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    want("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    want("rst_after", 0, 0, 0, 0, 0, 0, 0);
    tick();

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
